// File: rtl/axi_w_route_scheduler_if.sv
// W-channel route scheduler bus bundle.
// AW push side, per-master/per-slave W handshakes, route status.
interface axi_w_route_scheduler_if #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 8
);
  localparam int LOG_M = (M > 1) ? $clog2(M) : 1;
  localparam int LOG_N = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             aw_push;
  logic [LOG_M-1:0] aw_src;
  logic [LOG_N-1:0] aw_dst;
  logic [7:0]       aw_len;
  logic             aw_space;
  logic [M-1:0]     m_wvalid;
  logic [M-1:0]     m_wlast;
  logic [M-1:0]     m_wready;
  logic [N-1:0]     s_wvalid;
  logic [N-1:0]     s_wready;
  logic [LOG_M-1:0] w_sel_src;
  logic [LOG_N-1:0] w_sel_dst;
  logic             w_route_vld;
  logic [CW-1:0]    outstanding;
  logic             ovf_err;
  logic             len_err;

  modport slave (
    input  aw_push, aw_src, aw_dst, aw_len,
    input  m_wvalid, m_wlast, s_wready,
    output aw_space, m_wready, s_wvalid,
    output w_sel_src, w_sel_dst, w_route_vld,
    output outstanding, ovf_err, len_err
  );

  modport master (
    output aw_push, aw_src, aw_dst, aw_len,
    output m_wvalid, m_wlast, s_wready,
    input  aw_space, m_wready, s_wvalid,
    input  w_sel_src, w_sel_dst, w_route_vld,
    input  outstanding, ovf_err, len_err
  );
endinterface

// File: rtl/axi_w_route_scheduler.sv
// AXI4 crossbar W-channel route scheduler.
// In-order FIFO of AW bursts steers the shared W bus head-first.
module axi_w_route_scheduler #(
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 8,
  parameter int LOG_M = (M > 1) ? $clog2(M) : 1,
  parameter int LOG_N = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rstn,
  axi_w_route_scheduler_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [LOG_M-1:0] r_src [DEPTH];
  logic [LOG_N-1:0] r_dst [DEPTH];
  logic [7:0]       r_len [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic [7:0]       r_beat;
  logic             r_ovf;
  logic             r_lerr;

  logic             w_full;
  logic             w_vld;
  logic [LOG_M-1:0] w_h_src;
  logic [LOG_N-1:0] w_h_dst;
  logic [7:0]       w_h_len;
  logic             w_fire;
  logic             w_cnt_end;
  logic             w_last;
  logic             w_pop;
  logic             w_push;

  assign w_full  = (r_cnt == FULL);
  assign w_vld   = (r_cnt != '0);
  assign w_h_src = w_vld ? r_src[r_rd] : '0;
  assign w_h_dst = w_vld ? r_dst[r_rd] : '0;
  assign w_h_len = w_vld ? r_len[r_rd] : '0;

  assign w_fire = w_vld
                & bus.m_wvalid[w_h_src]
                & bus.s_wready[w_h_dst];
  assign w_cnt_end = (r_beat == w_h_len);
  assign w_last    = bus.m_wlast[w_h_src];
  assign w_pop     = w_fire & (w_cnt_end | w_last);
  assign w_push    = bus.aw_push & ~w_full;

  assign bus.aw_space    = ~w_full;
  assign bus.w_route_vld = w_vld;
  assign bus.w_sel_src   = w_h_src;
  assign bus.w_sel_dst   = w_h_dst;
  assign bus.outstanding = r_cnt;
  assign bus.ovf_err     = r_ovf;
  assign bus.len_err     = r_lerr;

  // Steer head source to head destination; everyone else held off.
  always_comb begin
    bus.s_wvalid = '0;
    bus.m_wready = '0;
    if (w_vld) begin
      bus.s_wvalid[w_h_dst] = bus.m_wvalid[w_h_src];
      bus.m_wready[w_h_src] = bus.s_wready[w_h_dst];
    end
  end

  // Burst entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_src[i] <= '0;
        r_dst[i] <= '0;
        r_len[i] <= '0;
      end
    end else if (w_push) begin
      r_src[r_wr] <= bus.aw_src;
      r_dst[r_wr] <= bus.aw_dst;
      r_len[r_wr] <= bus.aw_len;
    end
  end

  // Pointers, occupancy and per-burst beat counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_beat <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_pop)       r_beat <= '0;
      else if (w_fire) r_beat <= r_beat + 8'd1;
    end
  end

  // Sticky overflow and WLAST/AWLEN mismatch flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf  <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      if (bus.aw_push && w_full)          r_ovf  <= 1'b1;
      if (w_pop && (w_cnt_end ^ w_last))  r_lerr <= 1'b1;
    end
  end
endmodule
